mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single 16-bit memory port between the CPU core (requester 0) and a peripheral master such as an I/O loader or display scanner (requester 1). Each cycle it grants at most one access with a two-way round-robin, drives the memory address, write data and write-enable, and returns read data to the winner after a fixed memory latency. It sits between the CPU's memory interface and the block RAM, so the CPU stalls on `gnt0` instead of assuming it owns the port.

## Interface
- `WIDTH`, 16: data and address width.
- `READ_LAT`, 1: cycles from address issue to valid `mem_rdata`. Legal range 1–3.
- `clk` input 1: single clock.
- `reset` input 1: synchronous, active-high.
- `req0`, `req1` input 1: access request from CPU / peripheral. Held until granted.
- `we0`, `we1` input 1: 1 = write, 0 = read. Qualified by `req`.
- `adr0`, `adr1` input WIDTH: access address.
- `wdata0`, `wdata1` input WIDTH: write data.
- `gnt0`, `gnt1` output 1: access accepted this cycle. Combinational, one-hot or zero.
- `rvalid0`, `rvalid1` output 1: one-cycle pulse when `rdata` holds that requester's read result.
- `rdata` output WIDTH: registered read data, shared by both requesters.
- `mem_adr` output WIDTH: address to memory.
- `mem_wdata` output WIDTH: write data to memory.
- `mem_we` output 1: memory write-enable.
- `mem_rdata` input WIDTH: memory read data, valid `READ_LAT` cycles after issue.

## Operation
- States:
  - IDLE: the port is free.
  - RWAIT: a read is outstanding; a down-counter `lat_cnt` tracks the remaining latency.
- Grant rule in IDLE:
  - Only one request pending: it wins.
  - Both pending: the requester not served last wins.
  - `last` pointer resets to 1, so the CPU wins the first tie.
- No grants are issued in RWAIT. Requests keep waiting.
- Granted write:
  - `mem_we` = 1 and `mem_adr`/`mem_wdata` are taken from the winner in the same cycle.
  - The state stays IDLE, so back-to-back writes run at one per cycle.
- Granted read:
  - `mem_adr` = winner's address and `mem_we` = 0.
  - A 1-bit `owner` register and `lat_cnt` = `READ_LAT` are latched.
  - The state goes to RWAIT.
- RWAIT:
  - `lat_cnt` decrements each cycle.
  - When it reaches 1, `mem_rdata` is captured into `rdata`, `rvalid[owner]` pulses on the following cycle, and the state returns to IDLE.
  - A new grant may be issued in the same cycle `rvalid` is high.
- `last` updates to the winner on every grant, whether read or write.
- Outputs when there is no grant: `mem_we` = 0. `mem_adr` and `mem_wdata` hold their previous values, so they are registered-stable and not X.
- Requests that drop before being granted are legal and are simply ignored.

## Timing
- Reset values:
  - state = IDLE, `last` = 1, `owner` = 0, `lat_cnt` = 0.
  - `rvalid0` = `rvalid1` = 0, `rdata` = 0.
  - `mem_we` = 0, `mem_adr` = 0, `mem_wdata` = 0.
  - `gnt0` = `gnt1` = 0 while `reset` is high.
- Write latency: the grant and the memory write happen in cycle T.
- Read latency:
  - Grant and address in cycle T.
  - `rvalid` in cycle T+`READ_LAT`+1.
  - Next grant no earlier than T+`READ_LAT`+1.
- Reset asserted during RWAIT: the outstanding read is abandoned, no `rvalid` is issued, and the block returns to IDLE next cycle.
- Simultaneous events:
  - A request arriving in the `rvalid` cycle is eligible for grant in that cycle.
  - A requester whose read completes in a cycle may be granted again in that same cycle only if the other requester is not also requesting.

## Structure
- Package `arb_pkg` holds:
  - The state encoding: IDLE = 1'b0, RWAIT = 1'b1.
  - Requester index constants: REQ_CPU = 0, REQ_PERIPH = 1.
  - The maximum latency constant: MAX_LAT = 3.
- Sub-module `rr_pick2` is the combinational two-way round-robin picker. Inputs: `req0`, `req1`, `last`. Outputs: `gnt0`, `gnt1`, `winner`. It is reused by later multi-master arbiters.

## Test plan
- Reset, then `req0` write to adr 0x0010 with data 0xBEEF:
  - `gnt0` = 1 in the same cycle.
  - `mem_we` = 1, `mem_adr` = 0x0010, `mem_wdata` = 0xBEEF.
  - `last` = 0.
- Both requesters issue continuous writes (adr0 = 0x0001, adr1 = 0x0002): grants alternate 0,1,0,1, starting with 0.
- `READ_LAT` = 2, `req1` read of 0x0040 where memory holds 0x1234:
  - `gnt1` at T.
  - No grants at T+1 or T+2 even though `req0` is high.
  - `rvalid1` = 1 and `rdata` = 0x1234 at T+3.
  - `gnt0` at T+3.
- A read is granted, then `reset` is pulsed at T+1:
  - No `rvalid` ever appears.
  - All outputs return to their reset values.
  - The next tie is won by the CPU.
- Back-to-back CPU reads with `READ_LAT` = 1 and `req1` low: one read completes every 2 cycles and `rvalid0` pulses on alternate cycles.

Source files
------------

// File: rtl/arb_pkg.sv
// arb_pkg: shared types and constants for the memory port arbiter
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, RWAIT = 1'b1} state_t;
  localparam int REQ_CPU = 0;
  localparam int REQ_PERIPH = 1;
  localparam int MAX_LAT = 3;
endpackage

// File: rtl/rr_pick2.sv
// rr_pick2: combinational two-way round-robin picker
//   req0/req1 requests in, last = index served most recently
//   gnt0/gnt1 one-hot or zero grant, winner = index of the granted requester
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt0,
  output logic gnt1,
  output logic winner
);
  assign gnt0 = req0 & (~req1 | last);
  assign gnt1 = req1 & (~req0 | ~last);
  assign winner = gnt1;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between CPU (0) and a peripheral (1)
//   req/we/adr/wdata 0,1 : requester access inputs, held until gnt
//   gnt0/gnt1            : combinational grant, only while the port is idle
//   rvalid0/rvalid1/rdata: registered read return, shared data bus
//   mem_adr/mem_wdata/mem_we/mem_rdata : memory side, rdata valid READ_LAT after issue
import arb_pkg::*;
module mem_port_arbiter #(
  parameter int WIDTH = 16,
  parameter int READ_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] adr0,
  input  logic [WIDTH-1:0] adr1,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             rvalid0,
  output logic             rvalid1,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] mem_adr,
  output logic [WIDTH-1:0] mem_wdata,
  output logic             mem_we,
  input  logic [WIDTH-1:0] mem_rdata
);
  localparam int LW = $clog2(MAX_LAT + 1);
  state_t           r_state;
  logic             r_last;
  logic             r_owner;
  logic [LW-1:0]    r_lat;
  logic [1:0]       r_rvalid;
  logic [WIDTH-1:0] r_rdata;
  logic [WIDTH-1:0] r_adr;
  logic [WIDTH-1:0] r_wdata;
  logic             w_idle;
  logic             w_winner;
  logic             w_grant;
  logic             w_we;
  logic [WIDTH-1:0] w_adr;
  logic [WIDTH-1:0] w_wdata;
  // requests are masked here so the picker never grants during a read or reset
  assign w_idle = (r_state == IDLE) & ~reset;
  rr_pick2 u_pick (
    .req0   (req0 & w_idle),
    .req1   (req1 & w_idle),
    .last   (r_last),
    .gnt0   (gnt0),
    .gnt1   (gnt1),
    .winner (w_winner)
  );
  assign w_grant = gnt0 | gnt1;
  assign w_we    = gnt1 ? we1 : we0;
  assign w_adr   = gnt1 ? adr1 : adr0;
  assign w_wdata = gnt1 ? wdata1 : wdata0;
  // memory outputs follow the winner in the grant cycle, otherwise hold the last value
  assign mem_we    = w_grant & w_we;
  assign mem_adr   = w_grant ? w_adr : r_adr;
  assign mem_wdata = mem_we ? w_wdata : r_wdata;
  assign rvalid0   = r_rvalid[REQ_CPU];
  assign rvalid1   = r_rvalid[REQ_PERIPH];
  assign rdata     = r_rdata;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_lat    <= '0;
      r_rvalid <= '0;
      r_rdata  <= '0;
      r_adr    <= '0;
      r_wdata  <= '0;
    end else begin
      r_rvalid <= '0;
      if (w_grant) begin
        r_last <= w_winner;
        r_adr  <= w_adr;
        if (w_we) r_wdata <= w_wdata;
      end
      if (w_grant && !w_we) begin
        r_owner <= w_winner;
        r_lat   <= LW'(READ_LAT);
        r_state <= RWAIT;
      end else if (r_state == RWAIT) begin
        // last latency cycle: memory data is valid now, return it next cycle
        if (r_lat == LW'(1)) begin
          r_rdata           <= mem_rdata;
          r_rvalid[r_owner] <= 1'b1;
          r_lat             <= '0;
          r_state           <= IDLE;
        end else begin
          r_lat <= r_lat - LW'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of the arbiter at READ_LAT 1 and 2
module tb_mem_port_arbiter;
  logic clk = 0, reset = 1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [15:0] adr0 = 0, adr1 = 0, wdata0 = 0, wdata1 = 0;
  logic a_gnt0, a_gnt1, a_rv0, a_rv1, a_we;
  logic [15:0] a_rdata, a_adr, a_wdata, a_mrd;
  logic b_gnt0, b_gnt1, b_rv0, b_rv1, b_we;
  logic [15:0] b_rdata, b_adr, b_wdata, b_mrd;
  logic [15:0] a_p1 = 0, b_p1 = 0, b_p2 = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a == 16'h0040) ? 16'h1234 : (a ^ 16'hA5A5);
  endfunction
  always @(posedge clk) begin
    a_p1 <= a_adr;
    b_p1 <= b_adr;
    b_p2 <= b_p1;
  end
  assign a_mrd = memf(a_p1);
  assign b_mrd = memf(b_p2);
  mem_port_arbiter #(.WIDTH(16), .READ_LAT(1)) u_lat1 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(a_gnt0), .gnt1(a_gnt1), .rvalid0(a_rv0), .rvalid1(a_rv1), .rdata(a_rdata),
    .mem_adr(a_adr), .mem_wdata(a_wdata), .mem_we(a_we), .mem_rdata(a_mrd)
  );
  mem_port_arbiter #(.WIDTH(16), .READ_LAT(2)) u_lat2 (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .adr0(adr0), .adr1(adr1), .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(b_gnt0), .gnt1(b_gnt1), .rvalid0(b_rv0), .rvalid1(b_rv1), .rdata(b_rdata),
    .mem_adr(b_adr), .mem_wdata(b_wdata), .mem_we(b_we), .mem_rdata(b_mrd)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic mid;
    @(negedge clk);
  endtask
  task automatic do_reset;
    reset = 1;
    req0 = 0;
    req1 = 0;
    tick;
    tick;
    reset = 0;
  endtask
  initial begin
    req0 = 1;
    req1 = 1;
    tick;
    mid;
    chk("rst_gnt0", a_gnt0, 0);
    chk("rst_gnt1", b_gnt1, 0);
    chk("rst_rv", {a_rv0, a_rv1, b_rv0, b_rv1}, 0);
    chk("rst_rdata", {a_rdata, b_rdata}, 0);
    chk("rst_mem", {b_we, b_adr, b_wdata}, 0);
    do_reset;
    req0 = 1; we0 = 1; adr0 = 16'h0010; wdata0 = 16'hBEEF;
    mid;
    chk("w_gnt", {b_gnt0, b_gnt1}, 2'b10);
    chk("w_mem", {b_we, b_adr, b_wdata}, {1'b1, 16'h0010, 16'hBEEF});
    tick;
    req0 = 0;
    mid;
    chk("hold_mem", {b_we, b_adr, b_wdata}, {1'b0, 16'h0010, 16'hBEEF});
    tick;
    req0 = 1; req1 = 1; we1 = 1; adr1 = 16'h0002; wdata1 = 16'h5555;
    mid;
    chk("last0_tie", {b_gnt0, b_gnt1, b_adr}, {2'b01, 16'h0002});
    do_reset;
    req0 = 1; we0 = 1; adr0 = 16'h0001; wdata0 = 16'hAAAA;
    req1 = 1; we1 = 1; adr1 = 16'h0002; wdata1 = 16'h5555;
    for (int k = 0; k < 4; k++) begin
      mid;
      chk($sformatf("alt%0d", k), {b_gnt0, b_gnt1, b_we, b_adr, b_wdata},
          (k % 2 == 0) ? {2'b10, 1'b1, 16'h0001, 16'hAAAA} : {2'b01, 1'b1, 16'h0002, 16'h5555});
      tick;
    end
    do_reset;
    req1 = 1; we1 = 0; adr1 = 16'h0040;
    mid;
    chk("r_T", {b_gnt0, b_gnt1, b_we, b_adr}, {2'b01, 1'b0, 16'h0040});
    tick;
    req1 = 0; req0 = 1; we0 = 1; adr0 = 16'h0077; wdata0 = 16'h1111;
    mid;
    chk("r_T1", {b_gnt0, b_gnt1, b_we, b_rv1}, 0);
    tick;
    mid;
    chk("r_T2", {b_gnt0, b_gnt1, b_we, b_rv1}, 0);
    tick;
    mid;
    chk("r_T3_rv", {b_rv0, b_rv1, b_rdata}, {2'b01, 16'h1234});
    chk("r_T3_gnt", {b_gnt0, b_gnt1, b_we, b_adr}, {2'b10, 1'b1, 16'h0077});
    do_reset;
    req0 = 1; we0 = 0; adr0 = 16'h0050;
    mid;
    chk("ra_T", {b_gnt0, b_adr}, {1'b1, 16'h0050});
    tick;
    reset = 1; req0 = 0;
    mid;
    chk("ra_T1", {b_gnt0, b_gnt1}, 0);
    tick;
    reset = 0;
    mid;
    chk("ra_T2", {b_rv0, b_rv1, b_we, b_adr, b_wdata, b_rdata}, 0);
    tick;
    req0 = 1; req1 = 1; we0 = 1; we1 = 1; adr0 = 16'h0003; adr1 = 16'h0004;
    mid;
    chk("ra_T3_rv", {b_rv0, b_rv1}, 0);
    chk("ra_tie", {b_gnt0, b_gnt1, b_adr}, {2'b10, 16'h0003});
    do_reset;
    req0 = 1; we0 = 0; adr0 = 16'h0100;
    for (int k = 0; k < 6; k++) begin
      mid;
      chk($sformatf("b2b_gnt%0d", k), {a_gnt0, a_gnt1}, {k % 2 == 0, 1'b0});
      chk($sformatf("b2b_rv%0d", k), {a_rv0, a_rv1}, {k >= 2 && k % 2 == 0, 1'b0});
      if (k >= 2 && k % 2 == 0) chk($sformatf("b2b_rd%0d", k), a_rdata, 16'hA4A5);
      tick;
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
